// File: rtl/logic_issue_stage.sv
// Issue stage in front of the bitwise logic array: decodes logical ops into a
// minterm select, picks op2, and buffers two entries behind a registered in_ready.
module logic_issue_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_rs1,
    input  logic [DATA_WIDTH-1:0] in_rs2,
    input  logic [11:0]           in_imm,
    input  logic                  in_use_imm,
    input  logic [2:0]            in_funct3,
    input  logic                  in_funct7_5,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_op1,
    output logic [DATA_WIDTH-1:0] out_op2,
    output logic [3:0]            out_logic_sel,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic                  out_illegal
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] op1;
        logic [DATA_WIDTH-1:0] op2;
        logic [3:0]            sel;
        logic [TAG_WIDTH-1:0]  tag;
        logic                  illegal;
    } entry_t;

    entry_t in_entry;
    entry_t out_q;
    entry_t skid_q;
    entry_t out_d;

    logic out_valid_q;
    logic skid_valid_q;
    logic in_ready_q;
    logic out_valid_n;
    logic skid_valid_n;
    logic load_out;
    logic load_skid;
    logic accept;
    logic out_free;

    // sel bits: [3]=a&b, [2]=~a&b, [1]=a&~b, [0]=~a&~b; inverted forms are register-only
    always_comb begin
        in_entry.op1     = in_rs1;
        in_entry.op2     = in_use_imm ? {{(DATA_WIDTH-12){in_imm[11]}}, in_imm} : in_rs2;
        in_entry.tag     = in_tag;
        in_entry.sel     = 4'b0000;
        in_entry.illegal = 1'b0;
        if (in_funct7_5 && in_use_imm) begin
            in_entry.illegal = 1'b1;
        end else begin
            case (in_funct3)
                3'b111:  in_entry.sel = in_funct7_5 ? 4'b0010 : 4'b1000;
                3'b110:  in_entry.sel = in_funct7_5 ? 4'b1011 : 4'b1110;
                3'b100:  in_entry.sel = in_funct7_5 ? 4'b1001 : 4'b0110;
                default: in_entry.illegal = 1'b1;
            endcase
        end
    end

    assign accept   = in_valid & in_ready_q;
    assign out_free = ~out_valid_q | out_ready;

    // SKID always holds the older op, so it refills OUT before any new arrival
    always_comb begin
        out_valid_n  = out_valid_q;
        skid_valid_n = skid_valid_q;
        load_out     = 1'b0;
        load_skid    = 1'b0;
        out_d        = in_entry;
        if (out_free) begin
            if (skid_valid_q) begin
                load_out     = 1'b1;
                out_d        = skid_q;
                out_valid_n  = 1'b1;
                skid_valid_n = accept;
                load_skid    = accept;
            end else begin
                load_out    = accept;
                out_valid_n = accept;
            end
        end else if (accept) begin
            load_skid    = 1'b1;
            skid_valid_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            out_q        <= '0;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_n;
            skid_valid_q <= skid_valid_n;
            in_ready_q   <= ~skid_valid_n;
            if (load_out) begin
                out_q <= out_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_q <= in_entry;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign out_op1       = out_q.op1;
    assign out_op2       = out_q.op2;
    assign out_logic_sel = out_q.sel;
    assign out_tag       = out_q.tag;
    assign out_illegal   = out_q.illegal;

endmodule

// File: tb/tb_logic_issue_stage.sv
// Directed bench for logic_issue_stage: decode table, sign extension,
// backpressure ordering, a randomised stream against a queue, flush and reset.
module tb_logic_issue_stage;

    localparam int DW = 32;
    localparam int TW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_rs1;
    logic [DW-1:0] in_rs2;
    logic [11:0]   in_imm;
    logic          in_use_imm;
    logic [2:0]    in_funct3;
    logic          in_funct7_5;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_op1;
    logic [DW-1:0] out_op2;
    logic [3:0]    out_logic_sel;
    logic [TW-1:0] out_tag;
    logic          out_illegal;

    int checks   = 0;
    int failures = 0;

    logic [79:0] exp_q[$];
    int          received[$];

    logic_issue_stage #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .in_funct3(in_funct3),
        .in_funct7_5(in_funct7_5), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2),
        .out_logic_sel(out_logic_sel), .out_tag(out_tag),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] rs1, input logic [31:0] rs2, input logic [11:0] imm,
                                 input logic use_imm, input logic [2:0] f3, input logic f75,
                                 input logic [4:0] tag);
        in_valid    = 1'b1;
        in_rs1      = rs1;
        in_rs2      = rs2;
        in_imm      = imm;
        in_use_imm  = use_imm;
        in_funct3   = f3;
        in_funct7_5 = f75;
        in_tag      = tag;
    endtask

    // Reference decode, written straight from the encoding table
    function automatic logic [79:0] modelEntry(input logic [31:0] rs1, input logic [31:0] rs2,
                                               input logic [11:0] imm, input logic use_imm,
                                               input logic [2:0] f3, input logic f75,
                                               input logic [4:0] tag);
        logic [31:0] op2;
        logic [3:0]  sel;
        logic        ill;
        op2 = use_imm ? {{20{imm[11]}}, imm} : rs2;
        sel = 4'b0000;
        ill = 1'b0;
        case ({f75, use_imm, f3})
            5'b00111, 5'b01111: sel = 4'b1000;
            5'b00110, 5'b01110: sel = 4'b1110;
            5'b00100, 5'b01100: sel = 4'b0110;
            5'b10111:           sel = 4'b0010;
            5'b10110:           sel = 4'b1011;
            5'b10100:           sel = 4'b1001;
            default:            ill = 1'b1;
        endcase
        return {6'd0, rs1, op2, sel, tag, ill};
    endfunction

    task automatic runVector(input string name, input logic [31:0] rs1, input logic [31:0] rs2,
                             input logic [11:0] imm, input logic use_imm, input logic [2:0] f3,
                             input logic f75, input logic [4:0] tag, input logic [31:0] exp_op2,
                             input logic [3:0] exp_sel, input logic exp_ill);
        applyStimulus(rs1, rs2, imm, use_imm, f3, f75, tag);
        @(negedge clk);
        checkOutput({name, "_valid"}, out_valid, 1);
        checkOutput({name, "_op1"}, out_op1, rs1);
        checkOutput({name, "_op2"}, out_op2, exp_op2);
        checkOutput({name, "_sel"}, out_logic_sel, exp_sel);
        checkOutput({name, "_tag"}, out_tag, tag);
        checkOutput({name, "_illegal"}, out_illegal, exp_ill);
    endtask

    initial begin
        int next_tag;
        int accepted;
        int cycles;
        logic [31:0] r1, r2;
        logic [11:0] ri;
        logic        ru, rf;
        logic [2:0]  r3;
        logic [4:0]  rt;
        logic        rdy_before;
        logic [79:0] expv;

        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        in_use_imm = 1'b0; in_funct3 = '0; in_funct7_5 = 1'b0; in_tag = '0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_valid", out_valid, 0);
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_data", {out_op1, out_op2, out_logic_sel, out_tag, out_illegal}, 0);
        rst_n = 1'b1;

        runVector("and",  32'hF0F0_00FF, 32'h0FF0_0F0F, 12'h000, 0, 3'b111, 0, 5'd3, 32'h0FF0_0F0F, 4'b1000, 0);
        runVector("ori",  32'h1234_5678, 32'hDEAD_BEEF, 12'h800, 1, 3'b110, 0, 5'd4, 32'hFFFF_F800, 4'b1110, 0);
        runVector("xori", 32'h1234_5678, 32'hDEAD_BEEF, 12'h7FF, 1, 3'b100, 0, 5'd5, 32'h0000_07FF, 4'b0110, 0);
        runVector("andn", 32'hAAAA_5555, 32'h0000_FFFF, 12'h123, 0, 3'b111, 1, 5'd6, 32'h0000_FFFF, 4'b0010, 0);
        runVector("orn",  32'hAAAA_5555, 32'h00FF_00FF, 12'h123, 0, 3'b110, 1, 5'd7, 32'h00FF_00FF, 4'b1011, 0);
        runVector("xnor", 32'hAAAA_5555, 32'hFFFF_0000, 12'h123, 0, 3'b100, 1, 5'd8, 32'hFFFF_0000, 4'b1001, 0);
        runVector("f3_000", 32'h0BAD_F00D, 32'h1111_2222, 12'h000, 0, 3'b000, 0, 5'd9, 32'h1111_2222, 4'b0000, 1);
        runVector("xnor_imm", 32'h0BAD_F00D, 32'h1111_2222, 12'hF01, 1, 3'b100, 1, 5'd10, 32'hFFFF_FF01, 4'b0000, 1);
        runVector("f3_001", 32'h0000_0001, 32'h0000_0002, 12'h000, 0, 3'b001, 0, 5'd11, 32'h0000_0002, 4'b0000, 1);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("drained_valid", out_valid, 0);

        // Backpressure: only two ops fit while the output is held
        out_ready = 1'b0;
        next_tag  = 1;
        accepted  = 0;
        for (int c = 0; c < 5; c++) begin
            applyStimulus(32'h0000_00F0, 32'h0000_000F, 12'h000, 0, 3'b111, 0, next_tag[4:0]);
            if (in_valid && in_ready) begin
                accepted++;
                next_tag++;
            end
            @(negedge clk);
            checkOutput("bp_hold_valid", out_valid, 1);
            checkOutput("bp_hold_tag", out_tag, 1);
        end
        checkOutput("bp_accepted", accepted, 2);
        checkOutput("bp_in_ready", in_ready, 0);
        out_ready = 1'b1;
        cycles = 0;
        while (received.size() < 6 && cycles < 40) begin
            in_valid = (next_tag <= 6);
            in_tag   = next_tag[4:0];
            if (out_valid && out_ready) received.push_back(int'(out_tag));
            if (in_valid && in_ready) next_tag++;
            @(negedge clk);
            cycles++;
        end
        in_valid = 1'b0;
        checkOutput("bp_count", received.size(), 6);
        for (int i = 0; i < received.size(); i++) begin
            checkOutput("bp_order", received[i], i + 1);
        end
        @(negedge clk);
        checkOutput("bp_empty", out_valid, 0);

        // Randomised valid/ready traffic against an in-order queue
        accepted = 0;
        cycles   = 0;
        while (accepted < 300 && cycles < 6000) begin
            r1 = $urandom; r2 = $urandom; ri = 12'($urandom_range(0, 4095));
            ru = 1'($urandom_range(0, 1)); rf = 1'($urandom_range(0, 1));
            r3 = 3'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 31));
            applyStimulus(r1, r2, ri, ru, r3, rf, rt);
            in_valid   = ($urandom_range(0, 3) != 0);
            rdy_before = in_ready;
            out_ready  = ($urandom_range(0, 2) != 0);
            #1;
            if (out_ready == 1'b1) begin
                out_ready = 1'b0;
                #1;
                checkOutput("rnd_in_ready_indep", in_ready, rdy_before);
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("rnd_unexpected_out", 1, 0);
                end else begin
                    expv = exp_q.pop_front();
                    checkOutput("rnd_entry", {6'd0, out_op1, out_op2, out_logic_sel, out_tag, out_illegal}, expv);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(modelEntry(r1, r2, ri, ru, r3, rf, rt));
                accepted++;
            end
            @(negedge clk);
            cycles++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycles    = 0;
        while (exp_q.size() > 0 && cycles < 10) begin
            if (out_valid) begin
                expv = exp_q.pop_front();
                checkOutput("rnd_tail_entry", {6'd0, out_op1, out_op2, out_logic_sel, out_tag, out_illegal}, expv);
            end
            @(negedge clk);
            cycles++;
        end
        checkOutput("rnd_accepted", accepted, 300);
        checkOutput("rnd_queue_empty", exp_q.size(), 0);
        checkOutput("rnd_final_valid", out_valid, 0);

        // Flush with both entries occupied; the op offered alongside flush is dropped
        out_ready = 1'b0;
        applyStimulus(32'h1, 32'h2, 12'h0, 0, 3'b111, 0, 5'd10);
        @(negedge clk);
        in_tag = 5'd11;
        @(negedge clk);
        checkOutput("full_valid", out_valid, 1);
        checkOutput("full_in_ready", in_ready, 0);
        flush  = 1'b1;
        in_tag = 5'd12;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        checkOutput("flush_valid", out_valid, 0);
        checkOutput("flush_in_ready", in_ready, 1);
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("flush_no_ghost", out_valid, 0);

        // Reset mid-stream clears valids and the output data
        out_ready = 1'b0;
        applyStimulus(32'hCAFE_BABE, 32'h1234_0000, 12'h0, 0, 3'b110, 0, 5'd13);
        @(negedge clk);
        @(negedge clk);
        checkOutput("pre_reset_valid", out_valid, 1);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("mid_reset_valid", out_valid, 0);
        checkOutput("mid_reset_in_ready", in_ready, 1);
        checkOutput("mid_reset_data", {out_op1, out_op2, out_logic_sel, out_tag, out_illegal}, 0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_valid", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
